// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite round-robin interconnect:
// response codes and the read/write path state encodings.
package axi4_lite_pkg;

  // AXI response codes; the interconnect passes these through untouched.
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  // Read path: arbitrate, forward the address, then wait for the data beat.
  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_ADDR = 2'b01,
    R_DATA = 2'b10
  } r_state_e;

  // Write path: arbitrate, forward AW and W independently, then wait for B.
  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_AW_W = 2'b01,
    W_RESP = 2'b10
  } w_state_e;

endpackage

// File: rtl/axi4_lite_rr_interconnect_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping around. Produces a one-hot grant and its index.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;

  // Search [ptr..N-1] first, then wrap to [0..ptr-1].
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // a value held, which would otherwise infer a latch.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_rr_interconnect.sv
// N-master to 1-slave AXI4-Lite interconnect. Read and write paths each own
// a round-robin arbiter, a small FSM and a rotating priority pointer, so the
// two directions run concurrently with one outstanding transaction each.
module axi4_lite_rr_interconnect
  import axi4_lite_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  // master-side read
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_ar_addr,
  input  logic [NUM_MASTERS-1:0]            m_ar_valid,
  output logic [NUM_MASTERS-1:0]            m_ar_ready,
  output logic [NUM_MASTERS*DATA_W-1:0]     m_r_data,
  output logic [NUM_MASTERS*2-1:0]          m_r_resp,
  output logic [NUM_MASTERS-1:0]            m_r_valid,
  input  logic [NUM_MASTERS-1:0]            m_r_ready,
  // master-side write
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_aw_addr,
  input  logic [NUM_MASTERS-1:0]            m_aw_valid,
  output logic [NUM_MASTERS-1:0]            m_aw_ready,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_w_data,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_w_strb,
  input  logic [NUM_MASTERS-1:0]            m_w_valid,
  output logic [NUM_MASTERS-1:0]            m_w_ready,
  output logic [NUM_MASTERS*2-1:0]          m_b_resp,
  output logic [NUM_MASTERS-1:0]            m_b_valid,
  input  logic [NUM_MASTERS-1:0]            m_b_ready,
  // slave-side read
  output logic [ADDR_W-1:0]                 s_ar_addr,
  output logic                              s_ar_valid,
  input  logic                              s_ar_ready,
  input  logic [DATA_W-1:0]                 s_r_data,
  input  logic [1:0]                        s_r_resp,
  input  logic                              s_r_valid,
  output logic                              s_r_ready,
  // slave-side write
  output logic [ADDR_W-1:0]                 s_aw_addr,
  output logic                              s_aw_valid,
  input  logic                              s_aw_ready,
  output logic [DATA_W-1:0]                 s_w_data,
  output logic [DATA_W/8-1:0]               s_w_strb,
  output logic                              s_w_valid,
  input  logic                              s_w_ready,
  input  logic [1:0]                        s_b_resp,
  input  logic                              s_b_valid,
  output logic                              s_b_ready,
  // ownership
  output logic [NUM_MASTERS-1:0]            rd_grant,
  output logic [NUM_MASTERS-1:0]            wr_grant
);

  localparam int N      = NUM_MASTERS;
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

  // ---------------------------------------------------------------- read path
  r_state_e         r_state;
  logic [IDX_W-1:0] rd_idx, rd_ptr, rd_idx_c;
  logic [N-1:0]     rd_gnt_c;
  logic [IDX_W-1:0] rd_ptr_next;

  rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_rd_arb (
    .req     (m_ar_valid),
    .ptr     (rd_ptr),
    .gnt     (rd_gnt_c),
    .gnt_idx (rd_idx_c)
  );

  assign rd_ptr_next = (rd_idx == IDX_W'(N - 1)) ? '0 : rd_idx + 1'b1;

  // Read FSM: latch the winner, hold it until the R beat completes.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments and an async reset so
    // every register updates from pre-edge values and clears without a clock.
    if (!rst_n) begin
      r_state  <= R_IDLE;
      rd_grant <= '0;
      rd_idx   <= '0;
      rd_ptr   <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (|m_ar_valid) begin
          rd_grant <= rd_gnt_c;
          rd_idx   <= rd_idx_c;
          r_state  <= R_ADDR;
        end
        R_ADDR: if (s_ar_valid && s_ar_ready) r_state <= R_DATA;
        R_DATA: if (s_r_valid && s_r_ready) begin
          rd_ptr   <= rd_ptr_next;
          rd_grant <= '0;
          r_state  <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Route the granted master's AR to the slave and the R beat back to it.
  always_comb begin
    s_ar_addr = '0;
    for (int i = 0; i < N; i++)
      if (rd_grant[i]) s_ar_addr = m_ar_addr[i*ADDR_W +: ADDR_W];
    s_ar_valid = (r_state == R_ADDR) && |(m_ar_valid & rd_grant);
    m_ar_ready = (r_state == R_ADDR && s_ar_ready) ? rd_grant : '0;
    s_r_ready  = (r_state == R_DATA) && |(m_r_ready & rd_grant);
    m_r_valid  = (r_state == R_DATA && s_r_valid) ? rd_grant : '0;
  end

  assign m_r_data = {N{s_r_data}};
  assign m_r_resp = {N{s_r_resp}};

  // --------------------------------------------------------------- write path
  w_state_e         w_state;
  logic [IDX_W-1:0] wr_idx, wr_ptr, wr_idx_c;
  logic [N-1:0]     wr_gnt_c;
  logic [IDX_W-1:0] wr_ptr_next;
  logic             aw_done, w_done;
  logic             aw_hs, w_hs;

  // A master may present W before AW; either one counts as a request.
  rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_wr_arb (
    .req     (m_aw_valid | m_w_valid),
    .ptr     (wr_ptr),
    .gnt     (wr_gnt_c),
    .gnt_idx (wr_idx_c)
  );

  assign wr_ptr_next = (wr_idx == IDX_W'(N - 1)) ? '0 : wr_idx + 1'b1;
  assign aw_hs       = s_aw_valid && s_aw_ready;
  assign w_hs        = s_w_valid && s_w_ready;

  // Write FSM: AW and W complete in either order, then wait for B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state  <= W_IDLE;
      wr_grant <= '0;
      wr_idx   <= '0;
      wr_ptr   <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (|(m_aw_valid | m_w_valid)) begin
          wr_grant <= wr_gnt_c;
          wr_idx   <= wr_idx_c;
          w_state  <= W_AW_W;
        end
        W_AW_W: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs)) w_state <= W_RESP;
        end
        W_RESP: if (s_b_valid && s_b_ready) begin
          wr_ptr   <= wr_ptr_next;
          wr_grant <= '0;
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          w_state  <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Route the granted master's AW/W to the slave (each silenced once done)
  // and the B response back to it.
  always_comb begin
    s_aw_addr = '0;
    s_w_data  = '0;
    s_w_strb  = '0;
    for (int i = 0; i < N; i++) begin
      if (wr_grant[i]) begin
        s_aw_addr = m_aw_addr[i*ADDR_W +: ADDR_W];
        s_w_data  = m_w_data[i*DATA_W +: DATA_W];
        s_w_strb  = m_w_strb[i*STRB_W +: STRB_W];
      end
    end
    s_aw_valid = (w_state == W_AW_W) && !aw_done && |(m_aw_valid & wr_grant);
    s_w_valid  = (w_state == W_AW_W) && !w_done && |(m_w_valid & wr_grant);
    m_aw_ready = (w_state == W_AW_W && !aw_done && s_aw_ready) ? wr_grant : '0;
    m_w_ready  = (w_state == W_AW_W && !w_done && s_w_ready) ? wr_grant : '0;
    s_b_ready  = (w_state == W_RESP) && |(m_b_ready & wr_grant);
    m_b_valid  = (w_state == W_RESP && s_b_valid) ? wr_grant : '0;
  end

  assign m_b_resp = {N{s_b_resp}};

endmodule

// File: tb/tb_axi4_lite_rr_interconnect.sv
// Scoreboard bench for the AXI4-Lite round-robin interconnect. Stimulus pushes
// expected slave-side and master-side beats into queues; a negedge monitor
// pops and compares on every handshake. A small slave model answers requests.
module tb_axi4_lite_rr_interconnect;
  import axi4_lite_pkg::*;

  localparam int N   = 2;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N*AW-1:0] m_ar_addr, m_aw_addr;
  logic [N-1:0]    m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [N*DW-1:0] m_r_data, m_w_data;
  logic [N*2-1:0]  m_r_resp, m_b_resp;
  logic [N-1:0]    m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
  logic [N*SW-1:0] m_w_strb;
  logic [AW-1:0]   s_ar_addr, s_aw_addr;
  logic            s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic [DW-1:0]   s_r_data, s_w_data;
  logic [1:0]      s_r_resp, s_b_resp;
  logic            s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
  logic [SW-1:0]   s_w_strb;
  logic [N-1:0]    rd_grant, wr_grant;

  axi4_lite_rr_interconnect #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .rd_grant(rd_grant), .wr_grant(wr_grant)
  );

  typedef struct { int m; logic [AW-1:0] a; }                  addr_t;
  typedef struct { int m; logic [DW-1:0] d; logic [SW-1:0] s; } wbeat_t;
  typedef struct { int m; logic [DW-1:0] d; logic [1:0] r; }    rbeat_t;
  typedef struct { int m; logic [1:0] r; }                      bbeat_t;

  addr_t  exp_ar_q[$], exp_aw_q[$];
  wbeat_t exp_w_q[$];
  rbeat_t exp_r_q[$], rd_rsp_q[$];
  bbeat_t exp_b_q[$];
  logic [1:0] wr_rsp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int rd_lat = 3;
  int wr_lat = 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int m);
    return N'(1) << m;
  endfunction

  // Monitor: every handshake seen at the negedge must match the queue head.
  addr_t  ea;
  wbeat_t ew;
  rbeat_t er;
  bbeat_t eb;
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_ar_valid && s_ar_ready) begin
        if (exp_ar_q.size() == 0) check("s_ar_unexpected", 64'(exp_ar_q.size()), 64'd1);
        else begin
          ea = exp_ar_q.pop_front();
          check("s_ar_addr", s_ar_addr, ea.a);
          check("s_ar_owner", 64'(rd_grant), 64'(oh(ea.m)));
        end
      end
      if (|(m_r_valid & m_r_ready)) begin
        if (exp_r_q.size() == 0) check("m_r_unexpected", 64'(exp_r_q.size()), 64'd1);
        else begin
          er = exp_r_q.pop_front();
          check("m_r_valid_owner", 64'(m_r_valid), 64'(oh(er.m)));
          check("m_r_data", m_r_data[er.m*DW +: DW], er.d);
          check("m_r_resp", 64'(m_r_resp[er.m*2 +: 2]), 64'(er.r));
        end
      end
      if (s_aw_valid && s_aw_ready) begin
        if (exp_aw_q.size() == 0) check("s_aw_unexpected", 64'(exp_aw_q.size()), 64'd1);
        else begin
          ea = exp_aw_q.pop_front();
          check("s_aw_addr", s_aw_addr, ea.a);
          check("s_aw_owner", 64'(wr_grant), 64'(oh(ea.m)));
        end
      end
      if (s_w_valid && s_w_ready) begin
        if (exp_w_q.size() == 0) check("s_w_unexpected", 64'(exp_w_q.size()), 64'd1);
        else begin
          ew = exp_w_q.pop_front();
          check("s_w_data", s_w_data, ew.d);
          check("s_w_strb", 64'(s_w_strb), 64'(ew.s));
          check("s_w_owner", 64'(wr_grant), 64'(oh(ew.m)));
        end
      end
      if (|(m_b_valid & m_b_ready)) begin
        if (exp_b_q.size() == 0) check("m_b_unexpected", 64'(exp_b_q.size()), 64'd1);
        else begin
          eb = exp_b_q.pop_front();
          check("m_b_valid_owner", 64'(m_b_valid), 64'(oh(eb.m)));
          check("m_b_resp", 64'(m_b_resp[eb.m*2 +: 2]), 64'(eb.r));
        end
      end
    end
  end

  // Slave read model: accept AR, return the next queued response after rd_lat.
  initial begin : slave_rd
    int cnt;
    bit pend, hs_ar, hs_r;
    rbeat_t rb;
    s_r_valid = 1'b0; s_r_data = '0; s_r_resp = 2'b00;
    pend = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      hs_ar = s_ar_valid && s_ar_ready;
      hs_r  = s_r_valid && s_r_ready;
      @(posedge clk); #1;
      if (!rst_n) begin
        s_r_valid = 1'b0; pend = 1'b0;
      end else begin
        if (hs_r) s_r_valid = 1'b0;
        if (pend) begin
          if (cnt == 0) begin
            rb = (rd_rsp_q.size() != 0) ? rd_rsp_q.pop_front() : '{0, '0, 2'b00};
            s_r_data = rb.d; s_r_resp = rb.r; s_r_valid = 1'b1; pend = 1'b0;
          end else cnt--;
        end
        if (hs_ar) begin pend = 1'b1; cnt = rd_lat; end
      end
    end
  end

  // Slave write model: collect AW and W in any order, then answer B.
  initial begin : slave_wr
    int cnt;
    bit pend, aw_got, w_got, hs_aw, hs_w, hs_b;
    s_b_valid = 1'b0; s_b_resp = 2'b00;
    pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      hs_aw = s_aw_valid && s_aw_ready;
      hs_w  = s_w_valid && s_w_ready;
      hs_b  = s_b_valid && s_b_ready;
      @(posedge clk); #1;
      if (!rst_n) begin
        s_b_valid = 1'b0; pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
      end else begin
        if (hs_b) s_b_valid = 1'b0;
        if (pend) begin
          if (cnt == 0) begin
            s_b_resp  = (wr_rsp_q.size() != 0) ? wr_rsp_q.pop_front() : 2'b00;
            s_b_valid = 1'b1; pend = 1'b0;
          end else cnt--;
        end
        if (hs_aw) aw_got = 1'b1;
        if (hs_w)  w_got  = 1'b1;
        if (aw_got && w_got) begin aw_got = 1'b0; w_got = 1'b0; pend = 1'b1; cnt = wr_lat; end
      end
    end
  end

  // Master drivers: called at posedge+1, hold valid until the handshake.
  task automatic do_read(input int m, input logic [AW-1:0] addr);
    int n = 0;
    m_ar_addr[m*AW +: AW] = addr;
    m_ar_valid[m] = 1'b1;
    @(negedge clk);
    while (!m_ar_ready[m] && n < TMO) begin @(negedge clk); n++; end
    check("ar_handshake", 64'(m_ar_ready[m]), 64'd1);
    @(posedge clk); #1 m_ar_valid[m] = 1'b0;
  endtask

  task automatic do_aw(input int m, input logic [AW-1:0] addr);
    int n = 0;
    m_aw_addr[m*AW +: AW] = addr;
    m_aw_valid[m] = 1'b1;
    @(negedge clk);
    while (!m_aw_ready[m] && n < TMO) begin @(negedge clk); n++; end
    check("aw_handshake", 64'(m_aw_ready[m]), 64'd1);
    @(posedge clk); #1 m_aw_valid[m] = 1'b0;
  endtask

  task automatic do_w(input int m, input logic [DW-1:0] data, input logic [SW-1:0] strb);
    int n = 0;
    m_w_data[m*DW +: DW] = data;
    m_w_strb[m*SW +: SW] = strb;
    m_w_valid[m] = 1'b1;
    @(negedge clk);
    while (!m_w_ready[m] && n < TMO) begin @(negedge clk); n++; end
    check("w_handshake", 64'(m_w_ready[m]), 64'd1);
    @(posedge clk); #1 m_w_valid[m] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    int pending;
    pending = exp_ar_q.size() + exp_r_q.size() + exp_aw_q.size() + exp_w_q.size() + exp_b_q.size();
    while ((pending != 0 || rd_grant != '0 || wr_grant != '0) && n < TMO) begin
      @(negedge clk); n++;
      pending = exp_ar_q.size() + exp_r_q.size() + exp_aw_q.size() + exp_w_q.size() + exp_b_q.size();
    end
    check({name, "_drain"}, 64'(pending), 64'd0);
    check({name, "_grants_idle"}, 64'({rd_grant, wr_grant}), 64'd0);
  endtask

  // Assert reset between edges; every handshake output must drop at once.
  task automatic reset_dut(input string name);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check({name, "_rst_slave_side"}, 64'({s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, s_b_ready}), 64'd0);
    check({name, "_rst_master_ready"}, 64'({m_ar_ready, m_aw_ready, m_w_ready}), 64'd0);
    check({name, "_rst_master_valid"}, 64'({m_r_valid, m_b_valid}), 64'd0);
    check({name, "_rst_grants"}, 64'({rd_grant, wr_grant}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_bad %0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst_n = 1'b0;
    m_ar_addr = '0; m_ar_valid = '0; m_r_ready = '1;
    m_aw_addr = '0; m_aw_valid = '0; m_w_data = '0; m_w_strb = '0; m_w_valid = '0;
    m_b_ready = '1;
    s_ar_ready = 1'b1; s_aw_ready = 1'b1; s_w_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("init_grants", 64'({rd_grant, wr_grant}), 64'd0);
    check("init_slave_valids", 64'({s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, s_b_ready}), 64'd0);
    check("init_master_side", 64'({m_ar_ready, m_aw_ready, m_w_ready, m_r_valid, m_b_valid}), 64'd0);
    rst_n = 1'b1;

    // 1. Single read with registered grant latency
    rd_lat = 3;
    rd_rsp_q.push_back('{0, 64'hDEAD_BEEF, OKAY});
    exp_ar_q.push_back('{0, 64'h8000_0000});
    exp_r_q.push_back('{0, 64'hDEAD_BEEF, OKAY});
    @(posedge clk); #1;
    m_ar_addr[0 +: AW] = 64'h8000_0000;
    m_ar_valid[0] = 1'b1;
    @(negedge clk);
    check("t1_s_ar_valid_same_cycle", 64'(s_ar_valid), 64'd0);
    @(negedge clk);
    check("t1_s_ar_valid_next_cycle", 64'(s_ar_valid), 64'd1);
    check("t1_rd_grant", 64'(rd_grant), 64'b01);
    @(posedge clk); #1 m_ar_valid[0] = 1'b0;
    wait_drain("t1");

    // 2. Contention from a freshly reset pointer, then a second round
    reset_dut("t2");
    rd_lat = 1;
    rd_rsp_q.push_back('{0, 64'h1111_1111_0000_0000, OKAY});
    rd_rsp_q.push_back('{0, 64'h2222_2222_0000_0001, OKAY});
    exp_ar_q.push_back('{0, 64'h8000_1000});
    exp_ar_q.push_back('{1, 64'h8000_2000});
    exp_r_q.push_back('{0, 64'h1111_1111_0000_0000, OKAY});
    exp_r_q.push_back('{1, 64'h2222_2222_0000_0001, OKAY});
    @(posedge clk); #1;
    fork
      do_read(0, 64'h8000_1000);
      do_read(1, 64'h8000_2000);
    join
    wait_drain("t2a");
    rd_rsp_q.push_back('{0, 64'h3333_3333_0000_0002, OKAY});
    rd_rsp_q.push_back('{0, 64'h4444_4444_0000_0003, EXOKAY});
    exp_ar_q.push_back('{0, 64'h8000_3000});
    exp_ar_q.push_back('{1, 64'h8000_4000});
    exp_r_q.push_back('{0, 64'h3333_3333_0000_0002, OKAY});
    exp_r_q.push_back('{1, 64'h4444_4444_0000_0003, EXOKAY});
    @(posedge clk); #1;
    fork
      do_read(0, 64'h8000_3000);
      do_read(1, 64'h8000_4000);
    join
    wait_drain("t2b");

    // 3. Write with W two cycles ahead of AW
    wr_rsp_q.push_back(OKAY);
    exp_w_q.push_back('{1, 64'h1234, 8'hFF});
    exp_aw_q.push_back('{1, 64'h8000_0010});
    exp_b_q.push_back('{1, OKAY});
    @(posedge clk); #1;
    fork
      do_w(1, 64'h1234, 8'hFF);
      begin repeat (2) @(posedge clk); #1; do_aw(1, 64'h8000_0010); end
    join
    wait_drain("t3");

    // 4. Concurrent read (m0) and write (m1)
    rd_rsp_q.push_back('{0, 64'h0123_4567_89AB_CDEF, OKAY});
    exp_ar_q.push_back('{0, 64'h8000_0100});
    exp_r_q.push_back('{0, 64'h0123_4567_89AB_CDEF, OKAY});
    wr_rsp_q.push_back(OKAY);
    exp_aw_q.push_back('{1, 64'h8000_0200});
    exp_w_q.push_back('{1, 64'hCAFE, 8'h0F});
    exp_b_q.push_back('{1, OKAY});
    @(posedge clk); #1;
    fork
      do_read(0, 64'h8000_0100);
      do_aw(1, 64'h8000_0200);
      do_w(1, 64'hCAFE, 8'h0F);
      begin
        @(negedge clk); @(negedge clk);
        check("t4_rd_grant", 64'(rd_grant), 64'b01);
        check("t4_wr_grant", 64'(wr_grant), 64'b10);
      end
    join
    wait_drain("t4");

    // 5. SLVERR with master R backpressure for 4 cycles
    m_r_ready[0] = 1'b0;
    rd_rsp_q.push_back('{0, 64'hBAD0_BAD0, SLVERR});
    exp_ar_q.push_back('{0, 64'h8000_0300});
    exp_r_q.push_back('{0, 64'hBAD0_BAD0, SLVERR});
    @(posedge clk); #1;
    do_read(0, 64'h8000_0300);
    n = 0;
    while (!m_r_valid[0] && n < TMO) begin @(negedge clk); n++; end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_s_r_ready_low", 64'(s_r_ready), 64'd0);
      check("t5_m_r_valid_held", 64'(m_r_valid), 64'b01);
    end
    @(posedge clk); #1 m_r_ready[0] = 1'b1;
    @(negedge clk);
    check("t5_s_r_ready_released", 64'(s_r_ready), 64'd1);
    wait_drain("t5");

    // 6. Reset while the write path sits in W_RESP
    m_b_ready[1] = 1'b0;
    wr_rsp_q.push_back(OKAY);
    exp_aw_q.push_back('{1, 64'h8000_0400});
    exp_w_q.push_back('{1, 64'h5555, 8'h3C});
    @(posedge clk); #1;
    fork
      do_aw(1, 64'h8000_0400);
      do_w(1, 64'h5555, 8'h3C);
    join
    n = 0;
    while (!m_b_valid[1] && n < TMO) begin @(negedge clk); n++; end
    check("t6_b_pending_m1", 64'(m_b_valid), 64'b10);
    reset_dut("t6");
    m_b_ready = '1;
    // Pointer was 1 before reset; after reset m0 must win.
    rd_rsp_q.push_back('{0, 64'hA0A0_A0A0, OKAY});
    rd_rsp_q.push_back('{0, 64'hB1B1_B1B1, OKAY});
    exp_ar_q.push_back('{0, 64'h8000_0500});
    exp_ar_q.push_back('{1, 64'h8000_0600});
    exp_r_q.push_back('{0, 64'hA0A0_A0A0, OKAY});
    exp_r_q.push_back('{1, 64'hB1B1_B1B1, OKAY});
    wr_rsp_q.push_back(DECERR);
    exp_aw_q.push_back('{0, 64'h8000_0700});
    exp_w_q.push_back('{0, 64'h7777, 8'h81});
    exp_b_q.push_back('{0, DECERR});
    @(posedge clk); #1;
    fork
      do_read(0, 64'h8000_0500);
      do_read(1, 64'h8000_0600);
      do_aw(0, 64'h8000_0700);
      do_w(0, 64'h7777, 8'h81);
    join
    wait_drain("t6_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
